// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared constants and types for the writeback arbiter
package wb_arbiter_pkg;

  localparam int WB_ARB_MODE_FIXED = 0;
  localparam int WB_ARB_MODE_RR    = 1;

  localparam int WB_REG_WIDTH  = 5;
  localparam int WB_DATA_WIDTH = 32;

  // Field order matches wb_ix_inf_t so wb_* can be cast into it.
  typedef struct packed {
    logic [WB_REG_WIDTH-1:0]  rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  function automatic int wb_cnt_width(input int max_wait);
    return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_picker.sv
// rtl/wb_arb_picker.sv - combinational one-of-N picker: urgent first, then fixed or round-robin
module wb_arb_picker
  import wb_arbiter_pkg::*;
#(
  parameter  int NUM_PIPES = 4,
  parameter  int ARB_MODE  = WB_ARB_MODE_FIXED,
  localparam int IW        = $clog2(NUM_PIPES)
) (
  input  logic [NUM_PIPES-1:0] req_i,
  input  logic [NUM_PIPES-1:0] urgent_i,
  input  logic [IW-1:0]        rr_ptr_i,
  output logic [NUM_PIPES-1:0] grant_o,
  output logic [IW-1:0]        grant_idx_o,
  output logic                 grant_valid_o
);

  logic [NUM_PIPES-1:0] urgent_req;

  assign urgent_req = urgent_i & req_i;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NUM_PIPES) s = s - NUM_PIPES;
    return IW'(s);
  endfunction

  // Loops run downwards so the last hit (the lowest position) wins.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    if (|urgent_req) begin
      for (int i = NUM_PIPES - 1; i >= 0; i--) begin
        if (urgent_req[i]) grant_idx_o = IW'(i);
      end
      grant_valid_o = 1'b1;
    end else if (ARB_MODE == WB_ARB_MODE_RR) begin
      for (int k = NUM_PIPES - 1; k >= 0; k--) begin
        if (req_i[rr_idx(rr_ptr_i, k)]) grant_idx_o = rr_idx(rr_ptr_i, k);
      end
      grant_valid_o = |req_i;
    end else begin
      for (int i = NUM_PIPES - 1; i >= 0; i--) begin
        if (req_i[i]) grant_idx_o = IW'(i);
      end
      grant_valid_o = |req_i;
    end
    if (grant_valid_o) grant_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - N-pipe writeback arbiter with one-entry buffers, aging and registered write port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int NUM_PIPES  = 4,
  parameter  int DATA_WIDTH = WB_DATA_WIDTH,
  parameter  int REG_WIDTH  = WB_REG_WIDTH,
  parameter  int ARB_MODE   = WB_ARB_MODE_FIXED,
  parameter  int MAX_WAIT   = 8,
  localparam int IW         = $clog2(NUM_PIPES),
  localparam int CW         = wb_cnt_width(MAX_WAIT)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PIPES-1:0]            in_valid_i,
  output logic [NUM_PIPES-1:0]            in_ready_o,
  input  logic [NUM_PIPES*REG_WIDTH-1:0]  in_rd_i,
  input  logic [NUM_PIPES*DATA_WIDTH-1:0] in_data_i,
  output logic                            wb_wr_en_o,
  output logic [REG_WIDTH-1:0]            wb_rd_o,
  output logic [DATA_WIDTH-1:0]           wb_wr_data_o,
  output logic [IW-1:0]                   wb_pipe_id_o,
  output logic                            busy_o
);

  typedef struct packed {
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  logic [NUM_PIPES-1:0]  buf_valid_q, buf_valid_d;
  req_t                  buf_q [NUM_PIPES];
  req_t                  buf_d [NUM_PIPES];
  logic [CW-1:0]         wait_q [NUM_PIPES];
  logic [CW-1:0]         wait_d [NUM_PIPES];
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  wb_wr_en_q, wb_wr_en_d;
  logic [REG_WIDTH-1:0]  wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_wr_data_q, wb_wr_data_d;
  logic [IW-1:0]         wb_pipe_id_q, wb_pipe_id_d;

  logic [NUM_PIPES-1:0]  urgent;
  logic [NUM_PIPES-1:0]  grant;
  logic [NUM_PIPES-1:0]  accept;
  logic [IW-1:0]         grant_idx;
  logic                  grant_valid;

  always_comb begin
    urgent = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      urgent[i] = (MAX_WAIT > 0) && buf_valid_q[i] && (wait_q[i] == CW'(MAX_WAIT));
    end
  end

  wb_arb_picker #(
    .NUM_PIPES (NUM_PIPES),
    .ARB_MODE  (ARB_MODE)
  ) u_picker (
    .req_i         (buf_valid_q),
    .urgent_i      (urgent),
    .rr_ptr_i      (rr_ptr_q),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  // A buffer being drained this cycle can take a new result at the same edge.
  assign in_ready_o = ~buf_valid_q | grant;
  assign accept     = in_valid_i & in_ready_o;
  assign busy_o     = |buf_valid_q;

  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      buf_valid_d[i] = buf_valid_q[i];
      buf_d[i]       = buf_q[i];
      wait_d[i]      = '0;
      if (accept[i]) begin
        buf_valid_d[i]  = 1'b1;
        buf_d[i].rd     = in_rd_i[i*REG_WIDTH +: REG_WIDTH];
        buf_d[i].data   = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (grant[i]) begin
        buf_valid_d[i] = 1'b0;
      end else if (buf_valid_q[i]) begin
        wait_d[i] = (wait_q[i] == CW'(MAX_WAIT)) ? wait_q[i] : wait_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    wb_wr_en_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_wr_data_d = wb_wr_data_q;
    wb_pipe_id_d = wb_pipe_id_q;
    if (grant_valid) begin
      rr_ptr_d     = (int'(grant_idx) == NUM_PIPES - 1) ? '0 : grant_idx + IW'(1);
      wb_wr_en_d   = (buf_q[grant_idx].rd != '0);
      wb_rd_d      = buf_q[grant_idx].rd;
      wb_wr_data_d = buf_q[grant_idx].data;
      wb_pipe_id_d = grant_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid_q  <= '0;
      rr_ptr_q     <= '0;
      wb_wr_en_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_wr_data_q <= '0;
      wb_pipe_id_q <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        buf_q[i]  <= '0;
        wait_q[i] <= '0;
      end
    end else begin
      buf_valid_q  <= buf_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      wb_wr_en_q   <= wb_wr_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_wr_data_q <= wb_wr_data_d;
      wb_pipe_id_q <= wb_pipe_id_d;
      for (int i = 0; i < NUM_PIPES; i++) begin
        buf_q[i]  <= buf_d[i];
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign wb_wr_en_o   = wb_wr_en_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_wr_data_o = wb_wr_data_q;
  assign wb_pipe_id_o = wb_pipe_id_q;

endmodule
